// File: rtl/vrf_pkg.sv
// Shared types for the multi-port vector register file.
// Widths here are the default configuration; modules re-derive widths from their parameters.
package vrf_pkg;

    localparam int unsigned VRF_N     = 32;
    localparam int unsigned VRF_LANES = 8;

    typedef logic [VRF_N-1:0]      lane_t;
    typedef lane_t [VRF_LANES-1:0] vec_t;
    typedef logic [VRF_LANES-1:0]  mask_t;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } vrf_state_e;

endpackage

// File: rtl/vrf_mem.sv
// Vector storage array: one write port with per-lane enable, NUM_RD combinational read ports.
module vrf_mem #(
    parameter int unsigned WIDTH_ADDR   = 4,
    parameter int unsigned WIDTH_VECTOR = 8,
    parameter int unsigned N            = 32,
    parameter int unsigned NUM_RD       = 2
) (
    input  logic                                         clk,
    input  logic                                         we,
    input  logic [WIDTH_ADDR-1:0]                        waddr,
    input  logic [WIDTH_VECTOR-1:0]                      wmask,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]               wdata,
    input  logic [NUM_RD-1:0][WIDTH_ADDR-1:0]            raddr,
    output logic [NUM_RD-1:0][WIDTH_VECTOR-1:0][N-1:0]   rdata
);

    localparam int unsigned DEPTH = 2 ** WIDTH_ADDR;

    logic [WIDTH_VECTOR-1:0][N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned l = 0; l < WIDTH_VECTOR; l++) begin
                if (wmask[l]) begin
                    mem[waddr][l] <= wdata[l];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rdata[p] = mem[raddr[p]];
        end
    end

endmodule

// File: rtl/vec_reg_file_mp.sv
// Multi-port vector register file: masked write, write-first bypass, registered reads,
// optional zero-fill of every entry after reset.
module vec_reg_file_mp
    import vrf_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR     = 4,
    parameter int unsigned WIDTH_VECTOR   = 8,
    parameter int unsigned N              = 32,
    parameter int unsigned NUM_RD         = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    output logic                                         init_busy,
    input  logic                                         we,
    input  logic [WIDTH_ADDR-1:0]                        waddr,
    input  logic [WIDTH_VECTOR-1:0]                      wmask,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]               wdata,
    input  logic [NUM_RD-1:0]                            rd_en,
    input  logic [NUM_RD-1:0][WIDTH_ADDR-1:0]            raddr,
    output logic [NUM_RD-1:0]                            rvalid,
    output logic [NUM_RD-1:0][WIDTH_VECTOR-1:0][N-1:0]   rdata
);

    localparam vrf_state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    vrf_state_e            state_q, state_d;
    logic [WIDTH_ADDR-1:0] cnt_q, cnt_d;
    logic                  run;

    logic                                       mem_we;
    logic [WIDTH_ADDR-1:0]                      mem_addr;
    logic [WIDTH_VECTOR-1:0]                    mem_mask;
    logic [WIDTH_VECTOR-1:0][N-1:0]             mem_data;
    logic [NUM_RD-1:0][WIDTH_VECTOR-1:0][N-1:0] mem_rdata;
    logic [NUM_RD-1:0][WIDTH_VECTOR-1:0][N-1:0] rd_next;
    logic [NUM_RD-1:0]                          rd_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + WIDTH_ADDR'(1);
                if (cnt_q == '1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = RST_STATE;
        endcase
    end

    assign run       = (state_q == S_RUN);
    assign init_busy = !run;

    // Clear sequence borrows the single write port; user writes are dropped meanwhile.
    always_comb begin
        mem_we   = run ? we    : 1'b1;
        mem_addr = run ? waddr : cnt_q;
        mem_mask = run ? wmask : '1;
        mem_data = run ? wdata : '0;
    end

    vrf_mem #(
        .WIDTH_ADDR   (WIDTH_ADDR),
        .WIDTH_VECTOR (WIDTH_VECTOR),
        .N            (N),
        .NUM_RD       (NUM_RD)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_addr),
        .wmask (mem_mask),
        .wdata (mem_data),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_next = mem_rdata;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            for (int unsigned l = 0; l < WIDTH_VECTOR; l++) begin
                if (run && we && wmask[l] && (waddr == raddr[p])) begin
                    rd_next[p][l] = wdata[l];
                end
            end
        end
    end

    assign rd_fire = rd_en & {NUM_RD{run}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_fire;
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                if (rd_fire[p]) begin
                    rdata[p] <= rd_next[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_reg_file_mp.sv
// Directed plus randomized checks of vec_reg_file_mp against an array-based reference model.
module tb_vec_reg_file_mp;
    import vrf_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance with clear-on-reset
    logic                 init_busy;
    logic                 we;
    logic [AW-1:0]        waddr;
    mask_t                wmask;
    vec_t                 wdata;
    logic [NR-1:0]        rd_en;
    logic [NR-1:0][AW-1:0] raddr;
    logic [NR-1:0]        rvalid;
    vec_t [NR-1:0]        rdata;

    // Instance without clear phase
    logic                 init_busy1;
    logic                 we1;
    logic [AW-1:0]        waddr1;
    mask_t                wmask1;
    vec_t                 wdata1;
    logic [NR-1:0]        rd_en1;
    logic [NR-1:0][AW-1:0] raddr1;
    logic [NR-1:0]        rvalid1;
    vec_t [NR-1:0]        rdata1;

    vec_reg_file_mp #(
        .WIDTH_ADDR(AW), .WIDTH_VECTOR(VRF_LANES), .N(VRF_N), .NUM_RD(NR), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy), .we(we), .waddr(waddr),
        .wmask(wmask), .wdata(wdata), .rd_en(rd_en), .raddr(raddr),
        .rvalid(rvalid), .rdata(rdata)
    );

    vec_reg_file_mp #(
        .WIDTH_ADDR(AW), .WIDTH_VECTOR(VRF_LANES), .N(VRF_N), .NUM_RD(NR), .CLEAR_ON_RESET(1'b0)
    ) dut_nc (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy1), .we(we1), .waddr(waddr1),
        .wmask(wmask1), .wdata(wdata1), .rd_en(rd_en1), .raddr(raddr1),
        .rvalid(rvalid1), .rdata(rdata1)
    );

    // Reference model: contents after all completed writes, outstanding read results
    vec_t          mem_m [DEPTH];
    vec_t          exp_rd [NR];
    logic [NR-1:0] exp_v;
    int            clear_left;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        for (int p = 0; p < NR; p++) exp_rd[p] = '0;
        exp_v      = '0;
        clear_left = DEPTH;
    endtask

    // One clock: predict, advance past the edge, compare
    task automatic tick();
        logic busy;
        busy = (clear_left > 0);
        if (!busy && we) begin
            for (int l = 0; l < VRF_LANES; l++)
                if (wmask[l]) mem_m[waddr][l] = wdata[l];
        end
        for (int p = 0; p < NR; p++) begin
            exp_v[p] = rd_en[p] && !busy;
            if (exp_v[p]) exp_rd[p] = mem_m[raddr[p]];
        end
        @(posedge clk);
        #1;
        if (clear_left > 0) clear_left--;
        check("init_busy", 256'(init_busy), 256'(clear_left > 0));
        check("rvalid", 256'(rvalid), 256'(exp_v));
        for (int p = 0; p < NR; p++) check($sformatf("rdata[%0d]", p), 256'(rdata[p]), 256'(exp_rd[p]));
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wmask = '0; wdata = '0; rd_en = '0; raddr = '0;
    endtask

    task automatic check_reset_values();
        check("rst_rvalid", 256'(rvalid), 256'(0));
        check("rst_rdata0", 256'(rdata[0]), 256'(0));
        check("rst_rdata1", 256'(rdata[1]), 256'(0));
        check("rst_busy", 256'(init_busy), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v, nc_vec, held0, held1;
        int   nbusy;

        idle();
        we1 = 1'b0; waddr1 = '0; wmask1 = '0; wdata1 = '0; rd_en1 = '0; raddr1 = '0;
        model_reset();

        // Reset values, then release between edges
        #12;
        check_reset_values();
        check("nc_rst_rvalid", 256'(rvalid1), 256'(0));
        check("nc_rst_busy", 256'(init_busy1), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("nc_busy_after_release", 256'(init_busy1), 256'(0));

        // Without clear: write entry 0, then read it back
        for (int l = 0; l < VRF_LANES; l++) nc_vec[l] = $urandom;
        we1 = 1'b1; waddr1 = '0; wmask1 = '1; wdata1 = nc_vec;
        we = 1'b1; waddr = 4'd2; wmask = '1; wdata = nc_vec;   // dropped: clear in progress
        tick();
        we1 = 1'b0; rd_en1 = 2'b01; raddr1 = '0;
        tick();
        check("nc_rvalid", 256'(rvalid1), 256'(2'b01));
        check("nc_rdata0", 256'(rdata1[0]), 256'(nc_vec));
        rd_en1 = '0;

        // Reset pulsed at clear cycle 6 restarts the clear
        rd_en = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        nbusy = 0;
        for (int i = 0; i < 40 && init_busy; i++) begin
            we = 1'b1; waddr = 4'($urandom); wmask = '1; wdata[0] = $urandom;
            tick();
            nbusy++;
        end
        check("clear_cycles", 256'(nbusy), 256'(DEPTH));
        idle();

        // Every entry reads zero after the clear
        for (int e = 0; e < DEPTH; e += 2) begin
            rd_en = 2'b11; raddr[0] = 4'(e); raddr[1] = 4'(e + 1);
            tick();
            check("cleared_entry", 256'({rdata[1], rdata[0]}), 256'(0));
        end
        idle();
        tick();

        // Full write to entry 3, read the following cycle
        for (int l = 0; l < VRF_LANES; l++) v[l] = 32'(l + 1);
        we = 1'b1; waddr = 4'd3; wmask = 8'hFF; wdata = v;
        tick();
        idle(); rd_en = 2'b01; raddr[0] = 4'd3;
        tick();
        check("entry3_valid", 256'(rvalid[0]), 256'(1));
        check("entry3_data", 256'(rdata[0]), 256'(v));

        // Masked write with same-cycle read on port 1: bypass low lanes only
        idle(); we = 1'b1; waddr = 4'd5; wmask = 8'hFF;
        for (int l = 0; l < VRF_LANES; l++) wdata[l] = 32'hAAAA_AAAA;
        tick();
        wmask = 8'h0F;
        for (int l = 0; l < VRF_LANES; l++) wdata[l] = 32'h5555_5555;
        rd_en = 2'b10; raddr[1] = 4'd5;
        tick();
        for (int l = 0; l < VRF_LANES; l++) v[l] = (l < 4) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        check("bypass_p1", 256'(rdata[1]), 256'(v));

        // wmask=0 is a no-op write
        idle(); we = 1'b1; waddr = 4'd5; wmask = '0; wdata = '1; rd_en = 2'b01; raddr[0] = 4'd5;
        tick();
        check("mask0_noop", 256'(rdata[0]), 256'(v));

        // Both ports, then rd_en low holds data
        idle(); we = 1'b1; wmask = '1;
        waddr = 4'd7; for (int l = 0; l < VRF_LANES; l++) wdata[l] = $urandom;
        tick();
        waddr = 4'd9; for (int l = 0; l < VRF_LANES; l++) wdata[l] = $urandom;
        tick();
        idle(); rd_en = 2'b11; raddr[0] = 4'd7; raddr[1] = 4'd9;
        tick();
        held0 = rdata[0]; held1 = rdata[1];
        rd_en = '0;
        tick();
        check("hold_rvalid", 256'(rvalid), 256'(0));
        check("hold_rdata", 256'({rdata[1], rdata[0]}), 256'({held1, held0}));

        // Randomized traffic, addresses biased toward collisions
        for (int i = 0; i < 400; i++) begin
            we    = 1'($urandom);
            waddr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            wmask = 8'($urandom);
            for (int l = 0; l < VRF_LANES; l++) wdata[l] = $urandom;
            rd_en = 2'($urandom);
            for (int p = 0; p < NR; p++)
                raddr[p] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
